// File: rtl/pipe_tree_multiplier.sv
// pipe_tree_multiplier: pipelined WIDTH x WIDTH carry-save tree multiplier with valid/ready flow control.
// Define MULT_SIGNED_EN to add the sgn port and Baugh-Wooley two's-complement mode.
module pipe_tree_multiplier #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
`ifdef MULT_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] o
);
  localparam int PW = 2 * WIDTH;
`ifdef MULT_SIGNED_EN
  localparam int NR = WIDTH + 1;
`else
  localparam int NR = WIDTH;
`endif
  typedef logic [NR-1:0][PW-1:0] rows_t;

  function automatic int nxt(input int n);
    return n <= 2 ? n : 2 * (n / 3) + n % 3;
  endfunction

  function automatic int num_lvls();
    int n = NR;
    int l = 0;
    for (int i = 0; i < 64; i++)
      if (n > 2) begin
        n = nxt(n);
        l++;
      end
    return l;
  endfunction

  localparam int LVLS = num_lvls();
  localparam int G    = STAGES > 1 ? STAGES - 1 : 1;

  function automatic int cnt_at(input int l);
    int n = NR;
    for (int i = 0; i < LVLS; i++)
      if (i < l) n = nxt(n);
    return n;
  endfunction

  function automatic rows_t pp_rows(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    rows_t r = '0;
    for (int j = 0; j < WIDTH; j++)
      for (int i = 0; i < WIDTH; i++)
        r[j][i+j] = a[i] & b[j];
    return r;
  endfunction

`ifdef MULT_SIGNED_EN
  // Flips the mixed-sign partial products and sets the two Baugh-Wooley constant bits in the spare row.
  function automatic rows_t bw_fix(input logic s);
    rows_t m = '0;
    for (int j = 0; j < WIDTH; j++)
      for (int i = 0; i < WIDTH; i++)
        m[j][i+j] = s & ((i == WIDTH - 1) != (j == WIDTH - 1));
    m[WIDTH][WIDTH] = s;
    m[WIDTH][PW-1]  = s;
    return m;
  endfunction
`endif

  // One carry-save level: every full triple of rows becomes a sum row and a shifted carry row.
  function automatic rows_t csa_level(input rows_t r, input int n);
    rows_t s = '0;
    for (int t = 0; t < NR / 3; t++)
      if (3 * t + 2 < n) begin
        s[2*t]   = r[3*t] ^ r[3*t+1] ^ r[3*t+2];
        s[2*t+1] = ((r[3*t] & r[3*t+1]) | (r[3*t] & r[3*t+2]) | (r[3*t+1] & r[3*t+2])) << 1;
      end
    for (int t = 0; t < 2; t++)
      if (3 * (n / 3) + t < n) s[2*(n/3)+t] = r[3*(n/3)+t];
    return s;
  endfunction

  function automatic rows_t reduce(input rows_t r, input int lo, input int hi);
    rows_t s = r;
    for (int l = 0; l < LVLS; l++)
      if (l >= lo && l < hi) s = csa_level(s, cnt_at(l));
    return s;
  endfunction

  function automatic logic [PW-1:0] ks_add(input rows_t r);
    logic [PW-1:0] g = r[0] & r[1];
    logic [PW-1:0] p = r[0] ^ r[1];
    logic [PW-1:0] gn;
    logic [PW-1:0] pn;
    for (int d = 1; d < PW; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < PW; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    return r[0] ^ r[1] ^ {g[PW-2:0], 1'b0};
  endfunction

  logic [STAGES-1:0] v_q, v_d, adv;
  logic [STAGES:0]   go;
  rows_t             pp;
  rows_t             rows_q [G];
  rows_t             rows_d [G];
  logic [PW-1:0]     o_q, o_d;

`ifdef MULT_SIGNED_EN
  // sgn is consumed here; its effect rides down the pipe inside the partial-product rows.
  assign pp = pp_rows(x, y) ^ bw_fix(sgn);
`else
  assign pp = pp_rows(x, y);
`endif

  always_comb begin
    go = '0;
    go[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) go[k] = !v_q[k] | go[k+1];
    adv = go[STAGES-1:0];
    v_d = v_q;
    v_d[0] = adv[0] ? in_valid : v_q[0];
    for (int k = 1; k < STAGES; k++) v_d[k] = adv[k] ? v_q[k-1] : v_q[k];
    rows_d = rows_q;
    for (int k = 0; k < STAGES - 1; k++)
      if (adv[k]) rows_d[k] = reduce(k == 0 ? pp : rows_q[k == 0 ? 0 : k-1], LVLS * k / G, LVLS * (k + 1) / G);
    o_d = o_q;
    if (adv[STAGES-1]) o_d = STAGES == 1 ? ks_add(reduce(pp, 0, LVLS)) : ks_add(rows_q[G-1]);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v_q <= '0;
      o_q <= '0;
    end else begin
      v_q <= v_d;
      o_q <= o_d;
    end

  always_ff @(posedge clk) rows_q <= rows_d;

  assign in_ready  = adv[0];
  assign out_valid = v_q[STAGES-1];
  assign o         = o_q;
endmodule
